// File: rtl/mem_ctrl_pkg.sv
// Shared types and address decode for the banked memory controller.
// Regions map physical windows onto the text, user and kernel banks.
package mem_ctrl_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_TEXT,
        REG_USER,
        REG_KERN
    } region_t;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_WAIT,
        PS_DONE
    } port_state_t;

    function automatic logic in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int          aw
    );
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> (aw + 2)) == 32'd0);
    endfunction

    function automatic region_t decode_region(
        input logic [31:0] addr,
        input logic [31:0] text_base,
        input int          text_aw,
        input logic [31:0] user_base,
        input int          user_aw,
        input logic [31:0] kern_base,
        input int          kern_aw
    );
        region_t r;
        unique case (1'b1)
            in_range(addr, text_base, text_aw): r = REG_TEXT;
            in_range(addr, user_base, user_aw): r = REG_USER;
            in_range(addr, kern_base, kern_aw): r = REG_KERN;
            default:                            r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/banked_memory_controller_if.sv
// Instruction and data port bundle between the core memory stage
// and the banked memory controller.
interface banked_memory_controller_if #(
    parameter int DATA_W = 32
);
    logic                  ins_req;
    logic [31:0]           ins_addr;
    logic                  ins_busy;
    logic                  ins_done;
    logic [DATA_W-1:0]     ins_rdata;
    logic                  ins_err;

    logic                  data_req;
    logic                  data_write;
    logic [31:0]           data_addr;
    logic [DATA_W/8-1:0]   data_be;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_busy;
    logic                  data_done;
    logic [DATA_W-1:0]     data_rdata;
    logic                  data_err;

    modport master (
        output ins_req, ins_addr,
        output data_req, data_write, data_addr, data_be, data_wdata,
        input  ins_busy, ins_done, ins_rdata, ins_err,
        input  data_busy, data_done, data_rdata, data_err
    );

    modport slave (
        input  ins_req, ins_addr,
        input  data_req, data_write, data_addr, data_be, data_wdata,
        output ins_busy, ins_done, ins_rdata, ins_err,
        output data_busy, data_done, data_rdata, data_err
    );
endinterface

// File: rtl/mem_bank.sv
// Single-ported bank RAM with byte-enabled writes and registered read.
// Takes the physical address and strips its own base.
module mem_bank #(
    parameter int          DATA_W = 32,
    parameter int          AW     = 10,
    parameter logic [31:0] BASE   = 32'h0
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   q
);
    logic [DATA_W-1:0] mem [2**AW];
    logic [AW-1:0]     idx;

    assign idx = AW'((addr - BASE) >> 2);

    always_ff @(posedge clk) begin
        if (en) begin
            q <= mem[idx];
            if (we) begin
                for (int i = 0; i < DATA_W / 8; i++) begin
                    if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end
endmodule

// File: rtl/mem_port_fsm.sv
// One port's IDLE/WAIT/DONE sequencer with wait counter and
// read-data capture one cycle after grant.
module mem_port_fsm
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              bad,
    input  logic              grant,
    input  logic [DATA_W-1:0] bank_q,
    output logic              idle,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata
);
    localparam logic [WAIT_W-1:0] WC = WAIT_W'(WAIT_CYCLES);

    port_state_t       state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              cap_q;
    logic [DATA_W-1:0] rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            PS_IDLE: begin
                if (req && bad) begin
                    state_d = PS_DONE;
                    err_d   = 1'b1;
                end else if (grant) begin
                    err_d   = 1'b0;
                    cnt_d   = WC;
                    state_d = (WC == '0) ? PS_DONE : PS_WAIT;
                end
            end
            PS_WAIT: begin
                if (cnt_q <= WAIT_W'(1)) state_d = PS_DONE;
                else                     cnt_d   = cnt_q - 1'b1;
            end
            PS_DONE: state_d = PS_IDLE;
            default: state_d = PS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PS_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            cap_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cap_q   <= grant;
            if (cap_q) rdata_q <= bank_q;
            else if (idle && req && bad) rdata_q <= '0;
        end
    end

    // bank output is live only in the cycle after grant; hold it afterwards
    assign rdata = cap_q ? bank_q : rdata_q;
    assign idle  = (state_q == PS_IDLE);
    assign busy  = (state_q == PS_WAIT);
    assign done  = (state_q == PS_DONE);
    assign err   = done && err_q;
endmodule

// File: rtl/banked_memory_controller.sv
// Instruction and data ports over text, user and kernel banks with
// decode, error checks and round-robin arbitration on bank conflicts.
module banked_memory_controller
    import mem_ctrl_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          TEXT_AW     = 12,
    parameter int          USER_AW     = 12,
    parameter int          KERN_AW     = 10,
    parameter logic [31:0] TEXT_BASE   = 32'h0040_0000,
    parameter logic [31:0] USER_BASE   = 32'h1000_0000,
    parameter logic [31:0] KERN_BASE   = 32'hA000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input logic                      clk,
    input logic                      rst_n,
    banked_memory_controller_if.slave bus
);
    region_t           ins_reg, data_reg, ins_rq, data_rq;
    logic              ins_bad, data_bad, ins_idle, data_idle;
    logic              ins_ok, data_ok, conflict, ins_gnt, data_gnt;
    logic              rr_q;
    logic              ti, td, ui, ud, ki, kd;
    logic [DATA_W-1:0] q_text, q_user, q_kern, ins_q, data_q;

    function automatic logic [DATA_W-1:0] q_of(
        input region_t           r,
        input logic [DATA_W-1:0] qt,
        input logic [DATA_W-1:0] qu,
        input logic [DATA_W-1:0] qk
    );
        unique case (r)
            REG_TEXT: return qt;
            REG_USER: return qu;
            REG_KERN: return qk;
            default:  return '0;
        endcase
    endfunction

    assign ins_reg  = decode_region(bus.ins_addr, TEXT_BASE, TEXT_AW,
                                    USER_BASE, USER_AW, KERN_BASE, KERN_AW);
    assign data_reg = decode_region(bus.data_addr, TEXT_BASE, TEXT_AW,
                                    USER_BASE, USER_AW, KERN_BASE, KERN_AW);

    assign ins_bad  = (ins_reg == REG_NONE) || (bus.ins_addr[1:0] != 2'b00);
    assign data_bad = (data_reg == REG_NONE) || (bus.data_addr[1:0] != 2'b00)
                   || (bus.data_write && data_reg == REG_TEXT);

    assign ins_ok   = bus.ins_req && ins_idle && !ins_bad;
    assign data_ok  = bus.data_req && data_idle && !data_bad;
    assign conflict = ins_ok && data_ok && (ins_reg == data_reg);
    // rr_q set means the instruction port wins the next conflict
    assign ins_gnt  = ins_ok && (!conflict || rr_q);
    assign data_gnt = data_ok && (!conflict || !rr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= 1'b0;
            ins_rq  <= REG_NONE;
            data_rq <= REG_NONE;
        end else begin
            if (conflict) rr_q <= !rr_q;
            if (ins_gnt)  ins_rq <= ins_reg;
            if (data_gnt) data_rq <= data_reg;
        end
    end

    assign ti = ins_gnt && (ins_reg == REG_TEXT);
    assign td = data_gnt && (data_reg == REG_TEXT);
    assign ui = ins_gnt && (ins_reg == REG_USER);
    assign ud = data_gnt && (data_reg == REG_USER);
    assign ki = ins_gnt && (ins_reg == REG_KERN);
    assign kd = data_gnt && (data_reg == REG_KERN);

    mem_bank #(.DATA_W(DATA_W), .AW(TEXT_AW), .BASE(TEXT_BASE)) u_text (
        .clk(clk), .en(ti || td), .we(td && bus.data_write),
        .be(bus.data_be), .addr(ti ? bus.ins_addr : bus.data_addr),
        .wdata(bus.data_wdata), .q(q_text)
    );

    mem_bank #(.DATA_W(DATA_W), .AW(USER_AW), .BASE(USER_BASE)) u_user (
        .clk(clk), .en(ui || ud), .we(ud && bus.data_write),
        .be(bus.data_be), .addr(ui ? bus.ins_addr : bus.data_addr),
        .wdata(bus.data_wdata), .q(q_user)
    );

    mem_bank #(.DATA_W(DATA_W), .AW(KERN_AW), .BASE(KERN_BASE)) u_kern (
        .clk(clk), .en(ki || kd), .we(kd && bus.data_write),
        .be(bus.data_be), .addr(ki ? bus.ins_addr : bus.data_addr),
        .wdata(bus.data_wdata), .q(q_kern)
    );

    assign ins_q  = q_of(ins_rq, q_text, q_user, q_kern);
    assign data_q = q_of(data_rq, q_text, q_user, q_kern);

    mem_port_fsm #(.DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES)) u_ins (
        .clk(clk), .rst_n(rst_n), .req(bus.ins_req), .bad(ins_bad),
        .grant(ins_gnt), .bank_q(ins_q), .idle(ins_idle),
        .busy(bus.ins_busy), .done(bus.ins_done), .err(bus.ins_err),
        .rdata(bus.ins_rdata)
    );

    mem_port_fsm #(.DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES)) u_data (
        .clk(clk), .rst_n(rst_n), .req(bus.data_req), .bad(data_bad),
        .grant(data_gnt), .bank_q(data_q), .idle(data_idle),
        .busy(bus.data_busy), .done(bus.data_done), .err(bus.data_err),
        .rdata(bus.data_rdata)
    );
endmodule

// File: tb/tb_banked_memory_controller.sv
// Randomized bench for banked_memory_controller against an
// address-keyed memory model with arbitration-aware latency.
module tb_banked_memory_controller;
    localparam int W = 3;
    localparam logic [31:0] TB_TEXT = 32'h0040_0000;
    localparam logic [31:0] TB_USER = 32'h1000_0000;
    localparam logic [31:0] TB_KERN = 32'hA000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    banked_memory_controller_if #(.DATA_W(32)) bus ();

    banked_memory_controller #(.DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int vec = 0;
    int miss = 0;
    bit ins_first = 1'b0;
    logic [31:0] mdl [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // 0 none, 1 text, 2 user, 3 kern
    function automatic int region(input logic [31:0] a);
        if (a >= TB_TEXT && a < TB_TEXT + 32'h4000) return 1;
        if (a >= TB_USER && a < TB_USER + 32'h4000) return 2;
        if (a >= TB_KERN && a < TB_KERN + 32'h1000) return 3;
        return 0;
    endfunction

    function automatic bit is_bad(input bit dport, input bit wr,
                                  input logic [31:0] a);
        return region(a) == 0 || a[1:0] != 2'b00
            || (dport && wr && region(a) == 1);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] wd);
        logic [31:0] v;
        if (mdl.exists(a)) begin
            v = mdl[a];
            for (int i = 0; i < 4; i++) if (be[i]) v[i*8 +: 8] = wd[i*8 +: 8];
            mdl[a] = v;
        end else if (be == 4'hF) begin
            mdl[a] = wd;
        end
    endtask

    function automatic logic [31:0] user_w(input int i);
        return TB_USER + 32'(4 * (i == 8 ? 4095 : i));
    endfunction

    function automatic logic [31:0] kern_w(input int i);
        return TB_KERN + 32'(4 * (i == 8 ? 1023 : i));
    endfunction

    function automatic logic [31:0] pick_addr();
        int k;
        int i;
        k = $urandom_range(0, 11);
        i = $urandom_range(0, 8);
        case (k)
            0: return 32'h3000_0000 + 32'(4 * i);
            1: return user_w(i) + 32'($urandom_range(1, 3));
            2: return TB_TEXT + 32'(4 * i);
            3: return (i < 4) ? TB_KERN + 32'h1000 : TB_USER + 32'h4000;
            4, 5, 6, 7: return user_w(i);
            default: return kern_w(i);
        endcase
    endfunction

    task automatic run_pair(
        input  bit          di,
        input  logic [31:0] ia,
        input  bit          dd,
        input  bit          dw,
        input  logic [31:0] da,
        input  logic [3:0]  be,
        input  logic [31:0] wd,
        output logic [31:0] irdata,
        output logic [31:0] drdata
    );
        bit ib, db, conf, iknown, dknown, pi, pd, ins_turn;
        int ilat, dlat;
        logic [31:0] iexp, dexp;
        ib = is_bad(1'b0, 1'b0, ia);
        db = is_bad(1'b1, dw, da);
        conf = di && dd && !ib && !db && region(ia) == region(da);
        ilat = ib ? 1 : 1 + W;
        dlat = db ? 1 : 1 + W;
        if (conf) begin
            if (ins_first) dlat++;
            else ilat++;
        end
        iknown = 1'b0;
        dknown = 1'b0;
        iexp = '0;
        dexp = '0;
        for (int k = 0; k < 2; k++) begin
            ins_turn = (k == 0) == (conf ? ins_first : 1'b1);
            if (ins_turn) begin
                if (di && !ib && mdl.exists(ia)) begin
                    iknown = 1'b1;
                    iexp = mdl[ia];
                end
            end else if (dd && !db) begin
                if (dw) model_write(da, be, wd);
                else if (mdl.exists(da)) begin
                    dknown = 1'b1;
                    dexp = mdl[da];
                end
            end
        end
        if (conf) ins_first = !ins_first;

        @(posedge clk);
        #1;
        bus.ins_req    = di;
        bus.ins_addr   = ia;
        bus.data_req   = dd;
        bus.data_write = dw;
        bus.data_addr  = da;
        bus.data_be    = be;
        bus.data_wdata = wd;
        pi = di;
        pd = dd;
        irdata = '0;
        drdata = '0;
        for (int n = 0; n < 40 && (pi || pd); n++) begin
            @(negedge clk);
            if (pi && bus.ins_done) begin
                check("ins_latency", 32'(n), 32'(ilat));
                check("ins_err", 32'(bus.ins_err), 32'(ib));
                check("ins_busy_at_done", 32'(bus.ins_busy), 32'd0);
                if (iknown) check("ins_rdata", bus.ins_rdata, iexp);
                irdata = bus.ins_rdata;
                bus.ins_req = 1'b0;
                pi = 1'b0;
            end
            if (pd && bus.data_done) begin
                check("data_latency", 32'(n), 32'(dlat));
                check("data_err", 32'(bus.data_err), 32'(db));
                if (dknown && !dw) check("data_rdata", bus.data_rdata, dexp);
                drdata = bus.data_rdata;
                bus.data_req = 1'b0;
                pd = 1'b0;
            end
        end
        if (pi) check("ins_timeout", 32'd1, 32'd0);
        if (pd) check("data_timeout", 32'd1, 32'd0);
        bus.ins_req  = 1'b0;
        bus.data_req = 1'b0;
    endtask

    logic [31:0] ir, dr, t2;

    initial begin
        bus.ins_req    = 1'b0;
        bus.ins_addr   = '0;
        bus.data_req   = 1'b0;
        bus.data_write = 1'b0;
        bus.data_addr  = '0;
        bus.data_be    = '0;
        bus.data_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ins_busy", 32'(bus.ins_busy), 32'd0);
        check("rst_ins_done", 32'(bus.ins_done), 32'd0);
        check("rst_ins_err", 32'(bus.ins_err), 32'd0);
        check("rst_ins_rdata", bus.ins_rdata, 32'd0);
        check("rst_data_busy", 32'(bus.data_busy), 32'd0);
        check("rst_data_done", 32'(bus.data_done), 32'd0);
        check("rst_data_err", 32'(bus.data_err), 32'd0);
        check("rst_data_rdata", bus.data_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_pair(0, '0, 1, 1, user_w(i), 4'hF, $urandom, ir, dr);
            run_pair(0, '0, 1, 1, kern_w(i), 4'hF, $urandom, ir, dr);
        end

        run_pair(0, '0, 1, 1, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF, ir, dr);
        run_pair(0, '0, 1, 0, 32'h1000_0010, 4'h0, '0, ir, dr);
        check("dead_beef", dr, 32'hDEAD_BEEF);

        run_pair(0, '0, 1, 1, 32'h1000_0014, 4'hF, 32'h1122_3344, ir, dr);
        run_pair(0, '0, 1, 1, 32'h1000_0014, 4'b0101, 32'hAABB_CCDD, ir, dr);
        run_pair(0, '0, 1, 0, 32'h1000_0014, 4'h0, '0, ir, dr);
        check("byte_enable", dr, 32'h11BB_33DD);

        repeat (2)
            run_pair(1, 32'h1000_0010, 1, 0, 32'h1000_0014, 4'h0, '0, ir, dr);

        run_pair(1, 32'h0040_0000, 1, 0, 32'hA000_0004, 4'h0, '0, ir, dr);

        run_pair(1, 32'h0040_0008, 0, 0, '0, 4'h0, '0, t2, dr);
        run_pair(0, '0, 1, 0, 32'h3000_0000, 4'h0, '0, ir, dr);
        run_pair(0, '0, 1, 1, 32'h0040_0008, 4'hF, 32'hFFFF_FFFF, ir, dr);
        run_pair(1, 32'h0040_0002, 0, 0, '0, 4'h0, '0, ir, dr);
        run_pair(1, 32'h0040_0008, 0, 0, '0, 4'h0, '0, ir, dr);
        check("text_word2_kept", ir, t2);

        for (int it = 0; it < 120; it++) begin
            bit di, dd;
            di = 1'($urandom_range(0, 1));
            dd = !di || 1'($urandom_range(0, 1));
            run_pair(di, pick_addr(), dd, 1'($urandom_range(0, 1)),
                     pick_addr(), 4'($urandom_range(0, 15)), $urandom,
                     ir, dr);
        end

        @(posedge clk);
        #1;
        bus.data_req   = 1'b1;
        bus.data_write = 1'b1;
        bus.data_addr  = 32'h1000_0018;
        bus.data_be    = 4'hF;
        bus.data_wdata = 32'h5A5A_A5A5;
        model_write(32'h1000_0018, 4'hF, 32'h5A5A_A5A5);
        @(negedge clk);
        @(negedge clk);
        check("mid_wait_busy", 32'(bus.data_busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.data_busy), 32'd0);
        check("abort_done", 32'(bus.data_done), 32'd0);
        bus.data_req = 1'b0;
        ins_first = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_pair(0, '0, 1, 0, 32'h1000_0018, 4'h0, '0, ir, dr);
        check("write_before_reset", dr, 32'h5A5A_A5A5);
        run_pair(1, 32'hA000_0000, 1, 0, 32'hA000_0004, 4'h0, '0, ir, dr);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
